// File: rtl/imem_loader.sv
// imem_loader: streams little-endian bytes into 32-bit words and writes them
// to an instruction memory, holding the core stalled for the whole load.
//
// Ports:
//   clka, rsta          clock, synchronous active-high reset
//   start               load request, honoured only while idle
//   base_addr           first word address, latched on an accepted start
//   word_count          words to load, latched on an accepted start
//   rx_valid, rx_data   byte stream in
//   rx_ready            byte stream ready, high only while collecting
//   wea, addra, dina    imem write port, one-cycle write per word
//   busy, core_hold     high whenever a load is in progress
//   done                one-cycle completion pulse
//   err                 sticky flag for an oversize request
//   checksum            mod-2^32 sum of the words written by this/last load
module imem_loader #(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned CNT_W  = 10
) (
   input  logic              clka,
   input  logic              rsta,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              wea,
   output logic [ADDR_W-1:0] addra,
   output logic [31:0]       dina,
   output logic              busy,
   output logic              core_hold,
   output logic              done,
   output logic              err,
   output logic [31:0]       checksum
);

   // Wide enough to compare word_count against the memory depth.
   localparam int unsigned CMP_W = CNT_W + ADDR_W + 1;
   localparam logic [CMP_W-1:0] MAX_WORDS = CMP_W'(1) << ADDR_W;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2,
      FINISH  = 2'd3
   } state_t;

   state_t            state, state_d;
   logic [ADDR_W-1:0] addr, addr_d;
   logic [CNT_W-1:0]  remain, remain_d;
   logic [1:0]        byte_idx, byte_idx_d;
   logic [23:0]       shift, shift_d;

   logic              rx_ready_d, wea_d, busy_d, done_d, err_d;
   logic [ADDR_W-1:0] addra_d;
   logic [31:0]       dina_d, checksum_d;
   logic [CMP_W-1:0]  wc_ext;

   assign wc_ext = CMP_W'(word_count);

   // Next-state and next-output logic. Status outputs are registered from
   // the next state so they line up exactly with the state they describe.
   always_comb begin
      state_d    = state;
      addr_d     = addr;
      remain_d   = remain;
      byte_idx_d = byte_idx;
      shift_d    = shift;
      wea_d      = 1'b0;
      addra_d    = addra;
      dina_d     = dina;
      err_d      = err;
      checksum_d = checksum;

      case (state)
         IDLE: begin
            if (start) begin
               if (wc_ext == '0) begin
                  state_d    = FINISH;
                  checksum_d = '0;
               end else if (wc_ext > MAX_WORDS) begin
                  err_d = 1'b1;
               end else begin
                  state_d    = COLLECT;
                  addr_d     = base_addr;
                  remain_d   = word_count;
                  byte_idx_d = 2'd0;
                  checksum_d = '0;
                  err_d      = 1'b0;
               end
            end
         end
         COLLECT: begin
            if (rx_valid && rx_ready) begin
               if (byte_idx == 2'd3) begin
                  // Fourth byte completes the word; present it on the write port.
                  state_d = WRITE;
                  wea_d   = 1'b1;
                  addra_d = addr;
                  dina_d  = {rx_data, shift};
               end else begin
                  case (byte_idx)
                     2'd0:    shift_d[7:0]   = rx_data;
                     2'd1:    shift_d[15:8]  = rx_data;
                     default: shift_d[23:16] = rx_data;
                  endcase
                  byte_idx_d = byte_idx + 2'd1;
               end
            end
         end
         WRITE: begin
            checksum_d = checksum + dina;
            addr_d     = addr + ADDR_W'(1);
            remain_d   = remain - CNT_W'(1);
            byte_idx_d = 2'd0;
            state_d    = (remain == CNT_W'(1)) ? FINISH : COLLECT;
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      rx_ready_d = (state_d == COLLECT);
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == FINISH);
   end

   // State, datapath and output registers.
   always_ff @(posedge clka) begin
      if (rsta) begin
         state     <= IDLE;
         addr      <= '0;
         remain    <= '0;
         byte_idx  <= 2'd0;
         shift     <= '0;
         rx_ready  <= 1'b0;
         wea       <= 1'b0;
         addra     <= '0;
         dina      <= '0;
         busy      <= 1'b0;
         core_hold <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         checksum  <= '0;
      end else begin
         state     <= state_d;
         addr      <= addr_d;
         remain    <= remain_d;
         byte_idx  <= byte_idx_d;
         shift     <= shift_d;
         rx_ready  <= rx_ready_d;
         wea       <= wea_d;
         addra     <= addra_d;
         dina      <= dina_d;
         busy      <= busy_d;
         core_hold <= busy_d;
         done      <= done_d;
         err       <= err_d;
         checksum  <= checksum_d;
      end
   end

endmodule
